weight_route_controller: RTL
============================

Name: weight_route_controller

Overview:
Parametrised successor of the single-pass weight controller. Walks all output channels in groups of COUNT and writes one weight-segment address range per router lane. It supports pointwise (PWise) and depthwise (DWise) segment lengths and masks partial last groups. It sequences the route/compare/drain handshake with the tile reader and output FIFO, and parks between groups until the upper-level control grants the next context.

Parameters:
COUNT, 4, number of router lanes (address slots) per group; >=1
ADDR_WIDTH, 8, width of addresses and size fields
ID_WIDTH, max(1,$clog2(COUNT)), width of lane id

Ports:
i_clk  in  1  clock
i_rst  in  1  synchronous active-high reset
i_en  in  1  enable; i_start ignored while low
i_reg_clear  in  1  synchronous soft clear, identical effect to i_rst
i_start  in  1  one-cycle start pulse, sampled only in IDLE
i_conv_mode  in  1  0: PWise, 1: DWise; latched at start
i_start_addr  in  ADDR_WIDTH  weight base address; latched at start
i_i_c_size  in  ADDR_WIDTH  input channels (PWise segment length); latched
i_o_c_size  in  ADDR_WIDTH  output channels to walk; latched
i_k_size  in  ADDR_WIDTH  kernel elements per channel (DWise segment length); latched
i_pop_en  in  1  downstream pop request during drain
i_context_next  in  1  upper level grants next group
i_fifo_pop_ready  in  1  comparator/FIFO has data for current group
i_fifo_empty  in  1  output FIFO empty
o_id  out  ID_WIDTH  lane being written
o_start_addr  out  ADDR_WIDTH  segment first address
o_end_addr  out  ADDR_WIDTH  segment last address (inclusive)
o_addr_write_en  out  1  address write strobe
o_valid_mask  out  COUNT  lanes written in current group
o_group_idx  out  ADDR_WIDTH  current group number
o_route_en  out  1  enables tile reader and address comparator
o_pop_en  out  1  FIFO pop
o_reg_clear  out  1  one-cycle clear pulse to lane registers
o_ready  out  1  group data available
o_context_done  out  1  one-cycle pulse: non-final group drained
o_done  out  1  sticky: all channels done
o_busy  out  1  FSM not in IDLE

Behaviour:
- All outputs registered. On i_rst or i_reg_clear, all outputs are 0, FSM is IDLE and internal counters are 0. Clear wins over every simultaneous input.
- Segment length L = i_k_size (DWise) or i_i_c_size (PWise). Running address A starts at i_start_addr and advances by L per write. All sums wrap mod 2^ADDR_WIDTH. No multiplier is used.
- States: IDLE, ADDR_WRITE, WRITE_STALL, ROUTE, DRAIN, CTX_WAIT.
- IDLE: on i_en && i_start, latch params, clear o_done, c=0, group=0.
  - If o_c_size==0 or L==0: o_done=1 next cycle, no writes, stay IDLE.
  - Else go to ADDR_WRITE.
- ADDR_WRITE: one write per cycle. o_addr_write_en=1, o_id=lane, o_start_addr=A, o_end_addr=A+L-1. Set mask bit[lane], A+=L, c++.
  - The first strobe is the cycle after the start edge.
  - On lane==COUNT-1 or c==o_c_size-1: last write of the group, go to WRITE_STALL.
- WRITE_STALL: strobe 0, one cycle, then ROUTE.
- ROUTE: o_route_en=1 until i_fifo_pop_ready is seen. In that cycle: o_route_en=0, o_ready=1, go to DRAIN.
- DRAIN: o_pop_en <= i_pop_en each cycle. When i_fifo_empty (evaluated from the first DRAIN cycle; empty has priority over pop), apply all of the following next cycle:
  - o_pop_en=0, o_ready=0, one-cycle o_reg_clear.
  - If c==o_c_size: o_done=1, go to IDLE.
  - Else: one-cycle o_context_done, go to CTX_WAIT.
- CTX_WAIT: hold until i_context_next. Then lane=0, mask=0, group++, go to ADDR_WRITE. i_context_next in any other state is ignored.
- o_done holds until the next accepted start or clear. o_busy=1 in every non-IDLE state.

Test Plan:
1. COUNT=4, PWise, start=0x10, i_c=8, o_c=4 -> ids 0..3 on 4 consecutive cycles; ranges 0x10-17, 18-1F, 20-27, 28-2F; mask 1111; after pop_ready and empty, o_done=1, no context_done.
2. PWise, start=0x10, i_c=8, o_c=6 -> group0 as in scenario 1, then o_context_done pulse; stalls in CTX_WAIT for 10 cycles with no writes; after i_context_next: ids 0,1 with ranges 0x30-37, 38-3F, mask 0011, group_idx=1, then o_done.
3. DWise, start=0, k=9, i_c=32, o_c=3 -> ranges 0-8, 9-17, 18-26; mask 0111; i_c ignored.
4. Wrap case: start=0xF0, L=8, o_c=4 -> ranges F0-F7, F8-FF, 00-07, 08-0F.
5. Handshake: i_fifo_pop_ready raised 5 cycles into ROUTE -> o_route_en high exactly those cycles; in DRAIN, o_pop_en follows i_pop_en with 1-cycle lag; i_fifo_empty -> single o_reg_clear pulse.
6. i_rst asserted after 2 writes -> all outputs 0 next cycle, IDLE; start with o_c=0 -> o_done one cycle later, o_addr_write_en never high.

Source files
------------

// File: rtl/weight_route_controller.sv
// weight_route_controller
//   Walks all output channels in groups of COUNT lanes and writes one weight
//   segment address range per router lane. It then sequences the
//   route/compare/drain handshake with the tile reader and output FIFO, and
//   parks between groups until the upper level grants the next context.
//
// Ports
//   i_clk, i_rst             clock, synchronous active-high reset
//   i_en, i_start            start pulse, accepted only in IDLE while enabled
//   i_reg_clear              soft clear, same effect as i_rst
//   i_conv_mode              0: PWise (L = i_i_c_size), 1: DWise (L = i_k_size)
//   i_start_addr, i_i_c_size, i_o_c_size, i_k_size   job parameters, latched at start
//   i_pop_en, i_context_next, i_fifo_pop_ready, i_fifo_empty   handshake inputs
//   o_id, o_start_addr, o_end_addr, o_addr_write_en, o_valid_mask, o_group_idx
//                            lane address writes of the current group
//   o_route_en, o_pop_en, o_reg_clear, o_ready, o_context_done, o_done, o_busy
//                            handshake / status outputs (all registered)
//
// state       | meaning
// IDLE        | waiting for start; o_done holds the result of the last job
// ADDR_WRITE  | a lane address write is on the outputs this cycle
// WRITE_STALL | one idle cycle after the last write of a group
// ROUTE       | tile reader/comparator enabled, waiting for FIFO data
// DRAIN       | forwarding pops until the output FIFO is empty
// CTX_WAIT    | group finished, waiting for the next context grant
module weight_route_controller #(
  parameter int COUNT      = 4,
  parameter int ADDR_WIDTH = 8,
  parameter int ID_WIDTH   = (COUNT > 1) ? $clog2(COUNT) : 1
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_en,
  input  logic                  i_reg_clear,
  input  logic                  i_start,
  input  logic                  i_conv_mode,
  input  logic [ADDR_WIDTH-1:0] i_start_addr,
  input  logic [ADDR_WIDTH-1:0] i_i_c_size,
  input  logic [ADDR_WIDTH-1:0] i_o_c_size,
  input  logic [ADDR_WIDTH-1:0] i_k_size,
  input  logic                  i_pop_en,
  input  logic                  i_context_next,
  input  logic                  i_fifo_pop_ready,
  input  logic                  i_fifo_empty,
  output logic [ID_WIDTH-1:0]   o_id,
  output logic [ADDR_WIDTH-1:0] o_start_addr,
  output logic [ADDR_WIDTH-1:0] o_end_addr,
  output logic                  o_addr_write_en,
  output logic [COUNT-1:0]      o_valid_mask,
  output logic [ADDR_WIDTH-1:0] o_group_idx,
  output logic                  o_route_en,
  output logic                  o_pop_en,
  output logic                  o_reg_clear,
  output logic                  o_ready,
  output logic                  o_context_done,
  output logic                  o_done,
  output logic                  o_busy
);

  typedef enum logic [2:0] {
    IDLE, ADDR_WRITE, WRITE_STALL, ROUTE, DRAIN, CTX_WAIT
  } state_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] len_q;   // latched segment length L
  logic [ADDR_WIDTH-1:0] oc_q;    // latched output channel count
  logic [ADDR_WIDTH-1:0] addr_q;  // running address for the next write
  logic [ADDR_WIDTH-1:0] c_q;     // channels written so far
  logic [ID_WIDTH-1:0]   lane_q;  // lane of the next write
  logic                  last_q;  // write now on the outputs closes the group

  logic [ADDR_WIDTH-1:0] seg_len_in;
  logic [ADDR_WIDTH-1:0] wr_len, wr_addr, wr_c, wr_oc;
  logic [ID_WIDTH-1:0]   wr_lane;
  logic [COUNT-1:0]      wr_mask;
  logic                  wr_last;
  logic                  do_emit;

  // Writes are emitted on the edge that enters/continues ADDR_WRITE, so the
  // first strobe of a job is visible right after the start edge. In IDLE the
  // parameters are not latched yet, hence the muxes onto the raw inputs.
  always_comb begin
    seg_len_in = i_conv_mode ? i_k_size : i_i_c_size;
    wr_len     = (state == IDLE) ? seg_len_in   : len_q;
    wr_addr    = (state == IDLE) ? i_start_addr : addr_q;
    wr_oc      = (state == IDLE) ? i_o_c_size   : oc_q;
    wr_c       = (state == IDLE) ? '0 : c_q;
    wr_lane    = (state == ADDR_WRITE) ? lane_q : '0;
    wr_mask    = ((state == ADDR_WRITE) ? o_valid_mask : '0) | (COUNT'(1) << wr_lane);
    wr_last    = (wr_lane == ID_WIDTH'(COUNT - 1)) || (wr_c == wr_oc - ADDR_WIDTH'(1));
    do_emit    = 1'b0;
    case (state)
      IDLE:       do_emit = i_en && i_start && (i_o_c_size != '0) && (seg_len_in != '0);
      ADDR_WRITE: do_emit = !last_q;
      CTX_WAIT:   do_emit = i_context_next;
      default:    do_emit = 1'b0;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst || i_reg_clear) begin
      state           <= IDLE;
      len_q           <= '0;
      oc_q            <= '0;
      addr_q          <= '0;
      c_q             <= '0;
      lane_q          <= '0;
      last_q          <= 1'b0;
      o_id            <= '0;
      o_start_addr    <= '0;
      o_end_addr      <= '0;
      o_addr_write_en <= 1'b0;
      o_valid_mask    <= '0;
      o_group_idx     <= '0;
      o_route_en      <= 1'b0;
      o_pop_en        <= 1'b0;
      o_reg_clear     <= 1'b0;
      o_ready         <= 1'b0;
      o_context_done  <= 1'b0;
      o_done          <= 1'b0;
      o_busy          <= 1'b0;
    end else begin
      o_reg_clear    <= 1'b0;
      o_context_done <= 1'b0;
      case (state)
        IDLE: begin
          if (i_en && i_start) begin
            len_q       <= seg_len_in;
            oc_q        <= i_o_c_size;
            c_q         <= '0;
            o_group_idx <= '0;
            // empty job completes immediately without any write
            o_done      <= (i_o_c_size == '0) || (seg_len_in == '0);
          end
        end
        ADDR_WRITE: begin
          if (last_q) begin
            o_addr_write_en <= 1'b0;
            state           <= WRITE_STALL;
          end
        end
        WRITE_STALL: begin
          o_route_en <= 1'b1;
          state      <= ROUTE;
        end
        ROUTE: begin
          if (i_fifo_pop_ready) begin
            o_route_en <= 1'b0;
            o_ready    <= 1'b1;
            state      <= DRAIN;
          end
        end
        DRAIN: begin
          if (i_fifo_empty) begin
            o_pop_en    <= 1'b0;
            o_ready     <= 1'b0;
            o_reg_clear <= 1'b1;
            if (c_q == oc_q) begin
              o_done <= 1'b1;
              o_busy <= 1'b0;
              state  <= IDLE;
            end else begin
              o_context_done <= 1'b1;
              state          <= CTX_WAIT;
            end
          end else begin
            o_pop_en <= i_pop_en;
          end
        end
        CTX_WAIT: begin
          if (i_context_next) o_group_idx <= o_group_idx + ADDR_WIDTH'(1);
        end
        default: state <= IDLE;
      endcase

      if (do_emit) begin
        o_addr_write_en <= 1'b1;
        o_id            <= wr_lane;
        o_start_addr    <= wr_addr;
        o_end_addr      <= wr_addr + wr_len - ADDR_WIDTH'(1);
        o_valid_mask    <= wr_mask;
        addr_q          <= wr_addr + wr_len;
        c_q             <= wr_c + ADDR_WIDTH'(1);
        lane_q          <= wr_lane + ID_WIDTH'(1);
        last_q          <= wr_last;
        o_busy          <= 1'b1;
        state           <= ADDR_WRITE;
      end
    end
  end

endmodule
